stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count resolution in Hz (1/100 s); DIV = CLK_FREQ_HZ/TICK_HZ SHALL be an integer >= 2, checked at elaboration.
REQ-003 clk  input  1  single system clock; all logic SHALL be on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cnt_ctrl  input  2  run control from the stopwatch FSM: 00 ENABLE, 01 DISABLE, 10 RESET, 11 treated as DISABLE.
REQ-006 o_csec  output  8  centiseconds as two BCD digits, range 00-99.
REQ-007 o_sec  output  8  seconds as two BCD digits, range 00-59.
REQ-008 o_min  output  8  minutes as two BCD digits, range 00-59.
REQ-009 o_tick  output  1  one-cycle pulse, high in the cycle the time outputs show a newly incremented value.
REQ-010 o_rollover  output  1  one-cycle pulse, high in the cycle the time wraps from 59:59.99 to 00:00.00.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 while cnt_ctrl==ENABLE, width $clog2(DIV).
REQ-012 At the clock edge where prescaler==DIV-1 and cnt_ctrl==ENABLE, the prescaler SHALL return to 0 and the time SHALL increment by one centisecond on that same edge.
REQ-013 o_tick SHALL be registered, high for exactly the one cycle following the incrementing edge, aligned with the updated digits; the first o_tick after leaving RESET SHALL occur DIV cycles after ENABLE is first sampled.
REQ-014 Digit chain: csec units 9->0 carries to csec tens; csec tens 9->0 carries to sec units; sec 59->00 carries to min; min 59->00 is rollover; each digit SHALL stay within 0-9 (tens of sec/min within 0-5).
REQ-015 On rollover all digits SHALL become 00:00.00, o_rollover SHALL pulse coincident with o_tick, and counting SHALL continue without stopping.
REQ-016 DISABLE (and 11): prescaler and all digits SHALL hold their values, o_tick and o_rollover SHALL be 0; on return to ENABLE counting SHALL resume from the held prescaler value (no lost or gained fraction).
REQ-017 RESET: at the next edge the prescaler and all digits SHALL clear to 0, o_tick and o_rollover SHALL be 0; RESET SHALL take priority over a coincident prescaler wrap.
REQ-018 cnt_ctrl SHALL be sampled every cycle without handshake; changes take effect on the next edge.
REQ-019 All outputs SHALL be driven directly from registers (no combinational path from cnt_ctrl to outputs).

Reset
REQ-020 While rst_n==0: prescaler 0, o_csec/o_sec/o_min 8'h00, o_tick 0, o_rollover 0.
REQ-021 Reset assertion SHALL take effect immediately, independent of clk, including mid-count; deassertion is synchronised externally.

Structure
REQ-022 A shared package stopwatch_pkg SHALL hold the cnt_ctrl codes (ENABLE, DISABLE, RESET), the BCD limit constants (9, 5) and the default TICK_HZ; the upstream FSM and this block SHALL both import it.
REQ-023 One sub-module, bcd_digit_cnt (parameter MAX_VAL, inputs clk, rst_n, clr, inc; outputs 4-bit digit, carry), SHALL be instantiated six times to form the chain.

Verification (CLK_FREQ_HZ=10, TICK_HZ=1, DIV=10)
REQ-024 Reset then ENABLE for 10 cycles -> first o_tick on cycle 10, o_csec=8'h01; after 100 ticks o_csec=8'h00, o_sec=8'h01.
REQ-025 ENABLE 5 cycles, DISABLE 20 cycles, ENABLE -> o_tick 5 cycles after re-enable, digits frozen during DISABLE, no tick while disabled.
REQ-026 Force time to 59:59.99 (via counting), one more tick -> o_min/o_sec/o_csec=00/00/00, o_rollover and o_tick both high one cycle.
REQ-027 RESET asserted on the exact cycle prescaler==9 -> no tick, all outputs 00 next cycle; re-ENABLE gives first tick after 10 cycles.
REQ-028 rst_n pulsed low between clock edges at time 01:23.45 -> outputs 00 immediately, before the next edge.
REQ-029 cnt_ctrl=2'b11 for 30 cycles during counting -> identical to DISABLE (hold, no tick).

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: run-control codes,
// BCD digit limits and default count resolution.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    CTRL_ENABLE  = 2'b00,
    CTRL_DISABLE = 2'b01,
    CTRL_RESET   = 2'b10
  } cnt_ctrl_e;

  localparam int unsigned BCD_MAX_UNITS   = 9;
  localparam int unsigned BCD_MAX_TENS    = 5;
  localparam int unsigned DEFAULT_TICK_HZ = 100;

  function automatic logic is_ctrl(
    input logic [1:0] ctrl,
    input cnt_ctrl_e  code
  );
    return ctrl == code;
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Stopwatch counter bundle: run control in, BCD time
// and tick/rollover pulses out. slave = counter side.
interface stopwatch_counter_if;
  logic [1:0] cnt_ctrl;
  logic [7:0] o_csec;
  logic [7:0] o_sec;
  logic [7:0] o_min;
  logic       o_tick;
  logic       o_rollover;

  modport master (
    output cnt_ctrl,
    input  o_csec, o_sec, o_min,
    input  o_tick, o_rollover
  );

  modport slave (
    input  cnt_ctrl,
    output o_csec, o_sec, o_min,
    output o_tick, o_rollover
  );
endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit 0..MAX_VAL. Ports: clk, rst_n, clr, inc,
// digit (registered), carry (inc while at MAX_VAL).
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_VAL = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] MAX = 4'(MAX_VAL);

  logic [3:0] digit_q;
  logic       at_max;

  assign at_max = digit_q == MAX;
  assign carry  = inc & at_max;
  assign digit  = digit_q;

  // clr wins over inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else if (clr) begin
      digit_q <= '0;
    end else if (inc) begin
      digit_q <= at_max ? 4'd0 : digit_q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss.cc stopwatch counter. Ports: clk, rst_n, sw (slave):
// cnt_ctrl in; o_csec/o_sec/o_min BCD, o_tick, o_rollover out.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = DEFAULT_TICK_HZ
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_counter_if.slave  sw
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned W   = $clog2(DIV);
  localparam logic [W-1:0] PRE_MAX = W'(DIV - 1);

  if (DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_div_chk
    $error("stopwatch_counter: DIV must be an integer >= 2");
  end

  logic [W-1:0] pre_q, pre_d;
  logic         wrap;
  logic         clr;
  logic         tick_q, roll_q;

  logic [3:0] cu, ct, su, st, mu, mt;
  logic       c_cu, c_ct, c_su, c_st, c_mu, c_mt;

  assign clr = is_ctrl(sw.cnt_ctrl, CTRL_RESET);

  // 11 falls into default: hold like DISABLE
  always_comb begin
    pre_d = pre_q;
    wrap  = 1'b0;
    unique case (1'b1)
      is_ctrl(sw.cnt_ctrl, CTRL_RESET): begin
        pre_d = '0;
      end
      is_ctrl(sw.cnt_ctrl, CTRL_ENABLE): begin
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          wrap  = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= wrap;
      roll_q <= c_mt;
    end
  end

  bcd_digit_cnt #(.MAX_VAL(BCD_MAX_UNITS)) u_csec_u (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(wrap), .digit(cu), .carry(c_cu)
  );

  bcd_digit_cnt #(.MAX_VAL(BCD_MAX_UNITS)) u_csec_t (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(c_cu), .digit(ct), .carry(c_ct)
  );

  bcd_digit_cnt #(.MAX_VAL(BCD_MAX_UNITS)) u_sec_u (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(c_ct), .digit(su), .carry(c_su)
  );

  bcd_digit_cnt #(.MAX_VAL(BCD_MAX_TENS)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(c_su), .digit(st), .carry(c_st)
  );

  bcd_digit_cnt #(.MAX_VAL(BCD_MAX_UNITS)) u_min_u (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(c_st), .digit(mu), .carry(c_mu)
  );

  bcd_digit_cnt #(.MAX_VAL(BCD_MAX_TENS)) u_min_t (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(c_mu), .digit(mt), .carry(c_mt)
  );

  assign sw.o_csec     = {ct, cu};
  assign sw.o_sec      = {st, su};
  assign sw.o_min      = {mt, mu};
  assign sw.o_tick     = tick_q;
  assign sw.o_rollover = roll_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter at DIV=10 with a
// tick-count reference model and random control runs.
module tb_stopwatch_counter;
  import stopwatch_pkg::*;

  localparam int DIV    = 10;
  localparam int T_WRAP = 60 * 60 * 100;

  logic clk;
  logic rst_n;

  stopwatch_counter_if sw_if ();

  stopwatch_counter #(
    .CLK_FREQ_HZ(10),
    .TICK_HZ(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_pre  = 0;
  int m_t    = 0;
  bit m_tick = 0;
  bit m_roll = 0;

  logic [3:0] f0, f1, f2, f3, f4, f5;

  function automatic logic [7:0] bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".csec"}, 32'(sw_if.o_csec), 32'(bcd2(m_t % 100)));
    chk({tag, ".sec"},  32'(sw_if.o_sec),  32'(bcd2((m_t / 100) % 60)));
    chk({tag, ".min"},  32'(sw_if.o_min),  32'(bcd2(m_t / 6000)));
    chk({tag, ".tick"}, 32'(sw_if.o_tick), 32'(m_tick));
    chk({tag, ".roll"}, 32'(sw_if.o_rollover), 32'(m_roll));
  endtask

  // Time is kept as a plain count of centiseconds.
  task automatic model(input logic [1:0] c);
    m_tick = 0;
    m_roll = 0;
    if (c == 2'b10) begin
      m_pre = 0;
      m_t   = 0;
    end else if (c == 2'b00) begin
      if (m_pre == DIV - 1) begin
        m_pre  = 0;
        m_t    = m_t + 1;
        m_tick = 1;
        if (m_t == T_WRAP) begin
          m_t    = 0;
          m_roll = 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic step(input logic [1:0] c, input string tag);
    sw_if.cnt_ctrl = c;
    @(posedge clk);
    model(c);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input logic [1:0] c, input int n,
                       input string tag);
    for (int i = 0; i < n; i++) step(c, tag);
  endtask

  // Load a time into the digit registers while held.
  task automatic preload(input int t);
    f0 = 4'((t % 100) % 10);
    f1 = 4'((t % 100) / 10);
    f2 = 4'(((t / 100) % 60) % 10);
    f3 = 4'(((t / 100) % 60) / 10);
    f4 = 4'((t / 6000) % 10);
    f5 = 4'((t / 6000) / 10);
    sw_if.cnt_ctrl = 2'b01;
    force dut.u_csec_u.digit_q = f0;
    force dut.u_csec_t.digit_q = f1;
    force dut.u_sec_u.digit_q  = f2;
    force dut.u_sec_t.digit_q  = f3;
    force dut.u_min_u.digit_q  = f4;
    force dut.u_min_t.digit_q  = f5;
    #2;
    release dut.u_csec_u.digit_q;
    release dut.u_csec_t.digit_q;
    release dut.u_sec_u.digit_q;
    release dut.u_sec_t.digit_q;
    release dut.u_min_u.digit_q;
    release dut.u_min_t.digit_q;
    m_t = t;
    steps(2'b01, 2, "preload_hold");
  endtask

  initial begin
    logic [7:0] h_csec;
    int r;
    int n;
    logic [1:0] c;
    bit seen;

    rst_n = 1'b0;
    sw_if.cnt_ctrl = 2'b01;
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // first tick DIV cycles after ENABLE
    steps(2'b00, 9, "first_pre");
    chk("first_no_tick", 32'(sw_if.o_tick), 32'd0);
    step(2'b00, "first");
    chk("first_tick", 32'(sw_if.o_tick), 32'd1);
    chk("first_csec", 32'(sw_if.o_csec), 32'h01);
    steps(2'b00, 990, "hundred");
    chk("hundred_csec", 32'(sw_if.o_csec), 32'h00);
    chk("hundred_sec", 32'(sw_if.o_sec), 32'h01);

    // pause keeps the prescaler fraction
    step(2'b10, "p_clr");
    steps(2'b00, 5, "p_run");
    h_csec = sw_if.o_csec;
    steps(2'b01, 20, "p_hold");
    chk("p_frozen", 32'(sw_if.o_csec), 32'(h_csec));
    steps(2'b00, 4, "p_resume");
    chk("p_no_early", 32'(sw_if.o_tick), 32'd0);
    step(2'b00, "p_resume_tick");
    chk("p_tick5", 32'(sw_if.o_tick), 32'd1);

    // code 11 behaves as DISABLE
    steps(2'b00, 13, "c11_run");
    steps(2'b11, 30, "c11_hold");
    steps(2'b00, 20, "c11_resume");

    // RESET on the wrap cycle beats the tick
    seen = 0;
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      if (m_pre == DIV - 1) seen = 1;
      else step(2'b00, "rw_align");
    end
    chk("rw_aligned", 32'(seen), 32'd1);
    step(2'b10, "rw_reset");
    chk("rw_no_tick", 32'(sw_if.o_tick), 32'd0);
    chk("rw_csec", 32'(sw_if.o_csec), 32'h00);
    steps(2'b00, 9, "rw_pre");
    step(2'b00, "rw_first");
    chk("rw_tick10", 32'(sw_if.o_tick), 32'd1);

    // rollover from 59:59.98
    preload(T_WRAP - 2);
    chk("pl_min", 32'(sw_if.o_min), 32'h59);
    seen = 0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      step(2'b00, "roll_run");
      if (m_roll) seen = 1;
    end
    chk("roll_reached", 32'(seen), 32'd1);
    chk("roll_pulse", 32'(sw_if.o_rollover), 32'd1);
    chk("roll_tick", 32'(sw_if.o_tick), 32'd1);
    chk("roll_min", 32'(sw_if.o_min), 32'h00);
    steps(2'b00, 25, "roll_after");

    // async reset mid-count at 01:23.45
    preload(8345);
    steps(2'b00, 3, "ar_run");
    #3;
    rst_n = 1'b0;
    #1;
    m_pre = 0;
    m_t   = 0;
    m_tick = 0;
    m_roll = 0;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // random control runs against the model
    for (int s = 0; s < 150; s++) begin
      r = int'($urandom_range(0, 9));
      n = int'($urandom_range(1, 30));
      if (r <= 5) c = 2'b00;
      else if (r <= 7) c = 2'b01;
      else if (r == 8) c = 2'b11;
      else begin
        c = 2'b10;
        n = 1;
      end
      steps(c, n, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
